// File: rtl/orlink_mchan_engine.sv
// FX2 slave-FIFO protocol engine multiplexing NUM_CHAN byte streams over one header+count command format.
// Optional stall watchdog: define ORLINK_MCHAN_TIMEOUT_EN to turn a stuck command into a drain/pad.
module orlink_mchan_engine #(
    parameter int NUM_CHAN       = 4,
    parameter int PKT_BYTES      = 512,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  ifclk_in,
    input  logic                  wb_rst,
    inout  wire  [7:0]            fifoData_io,
    input  logic                  gotData_in,
    input  logic                  gotRoom_in,
    output logic                  sloe_out,
    output logic                  slrd_out,
    output logic                  slwr_out,
    output logic [1:0]            fifoAddr_out,
    output logic                  pktEnd_out,
    output logic [7:0]            h2f_data_o,
    output logic [NUM_CHAN-1:0]   h2f_valid_o,
    input  logic [NUM_CHAN-1:0]   h2f_ready_i,
    input  logic [8*NUM_CHAN-1:0] f2h_data_i,
    input  logic [NUM_CHAN-1:0]   f2h_valid_i,
    output logic [NUM_CHAN-1:0]   f2h_ready_o,
    output logic                  busy_o,
    output logic [6:0]            chan_o,
    output logic [1:0]            err_o,
    input  logic                  err_clr_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_DISPATCH, S_H2F_DATA, S_F2H_SETUP, S_F2H_DATA, S_F2H_END
    } state_t;

    localparam logic [31:0] PKT_MASK = 32'(PKT_BYTES - 1);

    state_t              state_q, state_d;
    logic [31:0]         count_q;
    logic [1:0]          idx_q;
    logic [6:0]          chan_q;
    logic                dir_q, inv_q, short_q;
    logic [1:0]          err_q, err_d;
    logic [NUM_CHAN-1:0] hit;
    logic [7:0]          chan_byte, bus_out;
    logic                ready_sel, valid_sel, h2f_xfer, f2h_xfer, hdr_bad, take_hdr, drive, timeout;

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_hit
            assign hit[gi] = (chan_q == 7'(gi));
        end
    endgenerate

    always_comb begin
        chan_byte = 8'h00;
        for (int c = 0; c < NUM_CHAN; c++)
            if (hit[c]) chan_byte = f2h_data_i[8*c +: 8];
    end

    assign h2f_data_o = fifoData_io;
    assign fifoData_io = drive ? bus_out : 8'hzz;
    assign ready_sel  = |(h2f_ready_i & hit);
    assign valid_sel  = |(f2h_valid_i & hit);
    assign h2f_xfer   = (state_q == S_H2F_DATA) & gotData_in & (ready_sel | inv_q);
    assign f2h_xfer   = (state_q == S_F2H_DATA) & gotRoom_in & (valid_sel | inv_q);
    assign hdr_bad    = ({25'd0, h2f_data_o[6:0]} >= 32'(NUM_CHAN));
    assign take_hdr   = (state_q == S_IDLE) & gotData_in;

    // After a timeout inv_q is set, so channel strobes stay gated even for an in-range channel.
    assign h2f_valid_o = hit & {NUM_CHAN{h2f_xfer & ~inv_q}};
    assign f2h_ready_o = hit & {NUM_CHAN{f2h_xfer & ~inv_q}};
    assign busy_o      = (state_q != S_IDLE);
    assign chan_o      = chan_q;
    assign err_o       = err_q;

`ifdef ORLINK_MCHAN_TIMEOUT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        timeout = 1'b0;
        if (h2f_xfer || f2h_xfer || state_q == S_DISPATCH) begin
            stall_d = 32'd0;
        end else if (!inv_q && ((state_q == S_H2F_DATA && gotData_in) ||
                                (state_q == S_F2H_DATA && gotRoom_in))) begin
            stall_d = stall_q + 32'd1;
            timeout = (stall_d == 32'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge ifclk_in or posedge wb_rst) begin
        if (wb_rst) stall_q <= 32'd0;
        else        stall_q <= stall_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Set-dominant: a new error in the same cycle as a clear survives.
    assign err_d = (err_clr_i ? 2'b00 : err_q) | {timeout, take_hdr & hdr_bad};

    always_ff @(posedge ifclk_in or posedge wb_rst) begin
        if (wb_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (gotData_in) state_d = S_CNT;
            S_CNT:       if (gotData_in && idx_q == 2'd3) state_d = S_DISPATCH;
            S_DISPATCH:  if (count_q == 32'd0) state_d = S_IDLE;
                         else state_d = dir_q ? S_F2H_SETUP : S_H2F_DATA;
            S_H2F_DATA:  if (h2f_xfer && count_q == 32'd1) state_d = S_IDLE;
            S_F2H_SETUP: state_d = S_F2H_DATA;
            S_F2H_DATA:  if (f2h_xfer && count_q == 32'd1) state_d = S_F2H_END;
            S_F2H_END:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sloe_out     = 1'b1;
        slrd_out     = 1'b1;
        slwr_out     = 1'b1;
        pktEnd_out   = 1'b1;
        fifoAddr_out = 2'b10;
        drive        = 1'b0;
        bus_out      = 8'h00;
        case (state_q)
            S_IDLE, S_CNT: begin
                sloe_out = ~gotData_in;
                slrd_out = ~gotData_in;
            end
            S_H2F_DATA: begin
                sloe_out = ~h2f_xfer;
                slrd_out = ~h2f_xfer;
            end
            S_F2H_SETUP: fifoAddr_out = 2'b11;
            S_F2H_DATA: begin
                fifoAddr_out = 2'b11;
                drive        = 1'b1;
                bus_out      = inv_q ? 8'h00 : chan_byte;
                slwr_out     = ~f2h_xfer;
            end
            S_F2H_END: begin
                fifoAddr_out = 2'b11;
                pktEnd_out   = ~short_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ifclk_in or posedge wb_rst) begin
        if (wb_rst) begin
            count_q <= 32'd0;
            idx_q   <= 2'd0;
            chan_q  <= 7'd0;
            dir_q   <= 1'b0;
            inv_q   <= 1'b0;
            short_q <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            err_q <= err_d;
            if (timeout) inv_q <= 1'b1;
            case (state_q)
                S_IDLE: if (gotData_in) begin
                    dir_q  <= h2f_data_o[7];
                    chan_q <= h2f_data_o[6:0];
                    inv_q  <= hdr_bad;
                    idx_q  <= 2'd0;
                end
                S_CNT: if (gotData_in) begin
                    count_q <= {count_q[23:0], h2f_data_o};
                    idx_q   <= idx_q + 2'd1;
                end
                S_DISPATCH: short_q <= ((count_q & PKT_MASK) != 32'd0);
                S_H2F_DATA: if (h2f_xfer) count_q <= count_q - 32'd1;
                S_F2H_DATA: if (f2h_xfer) count_q <= count_q - 32'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/orlink_mchan_engine.md
Name: orlink_mchan_engine

Overview:
- Next-generation FX2 slave-FIFO protocol engine in the ifclk_in domain.
- Generalises the fixed two-register link engine to NUM_CHAN byte-stream channels, each with valid/ready handshakes in both directions.
- Adds correct zero-count handling, short-packet commit on any PKT_BYTES boundary, and invalid-channel drain/pad.
- Sits between the FX2 pins and per-channel consumers: register banks, clock-crossing FIFOs to the Wishbone bridge, and similar.

Parameters:
- NUM_CHAN, 4, number of channels, 1..128.
- PKT_BYTES, 512, FX2 IN packet size; power of two.
- TIMEOUT_CYCLES, 65536, stall limit. Used only with ORLINK_MCHAN_TIMEOUT_EN.

Ports:
- ifclk_in  in  1  FX2 interface clock; all logic rising-edge.
- wb_rst  in  1  reset, asynchronous, active-high.
- fifoData_io  inout  8  FX2 data bus; driven only in F2H_DATA, otherwise high-Z.
- gotData_in  in  1  FX2 OUT FIFO not empty.
- gotRoom_in  in  1  FX2 IN FIFO not full.
- sloe_out, slrd_out, slwr_out  out  1 each  active-low FX2 strobes.
- fifoAddr_out  out  2  2'b10 = OUT FIFO, 2'b11 = IN FIFO.
- pktEnd_out  out  1  active-low packet commit.
- h2f_data_o  out  8  host-to-FPGA byte, shared by all channels (equals fifoData_io).
- h2f_valid_o  out  NUM_CHAN  one-hot valid.
- h2f_ready_i  in  NUM_CHAN  per-channel ready.
- f2h_data_i  in  8*NUM_CHAN  channel c occupies bits [8c+7:8c].
- f2h_valid_i  in  NUM_CHAN  per-channel valid.
- f2h_ready_o  out  NUM_CHAN  one-hot ready.
- busy_o  out  1  high when state is not IDLE.
- chan_o  out  7  channel of the current command.
- err_o  out  2  sticky; [0] = bad channel, [1] = timeout.
- err_clr_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset values:
  - state = IDLE; count, chan_o, err_o = 0.
  - Strobes: sloe/slrd/slwr = 1; pktEnd_out = 1; fifoAddr_out = 2'b10.
  - fifoData_io is high-Z; all valid/ready outputs = 0.
  - Reset mid-command aborts immediately. No pktEnd pulse, no partial handshake.
- Command format: header byte (bit7 dir: 1 = F2H, 0 = H2F; bits[6:0] channel), then a 32-bit count, MSB first.
- Header bytes: read-strobe outputs (slrd, sloe) asserted (low) while gotData_in is high. A byte is taken on each edge with gotData_in = 1.
- Channel validity: chan >= NUM_CHAN is marked invalid and sets err_o[0].
- States:
  - IDLE: take header -> CNT.
  - CNT: take 4 count bytes (2-bit index) -> DISPATCH.
  - DISPATCH (1 cycle):
    - count == 0 -> IDLE, no strobes, no pktEnd.
    - dir = 0 -> H2F_DATA.
    - dir = 1 -> F2H_SETUP.
  - H2F_DATA:
    - Transfer condition: xfer = gotData_in & (h2f_ready_i[chan] | invalid).
    - slrd/sloe low iff xfer; h2f_valid_o[chan] = xfer & ~invalid, combinational.
    - Each xfer decrements count; count reaching 0 -> IDLE.
    - Invalid channel: bytes are drained and discarded.
  - F2H_SETUP: fifoAddr_out = 2'b11, bus not driven; one cycle of turnaround -> F2H_DATA.
  - F2H_DATA:
    - Drive bus with f2h_data_i[chan], or 0x00 if invalid.
    - Transfer condition: xfer = gotRoom_in & (f2h_valid_i[chan] | invalid); slwr low iff xfer.
    - f2h_ready_o[chan] = xfer & ~invalid.
    - Decrement count; last byte -> F2H_END.
  - F2H_END (1 cycle, fifoAddr = 2'b11): pktEnd_out = 0 iff original count mod PKT_BYTES != 0. Full packets auto-commit. -> IDLE.
- Latency:
  - Data is pass-through combinational: one byte per cycle at full rate.
  - Header + count + dispatch = 6 cycles minimum.
- Counter is 32-bit. The count is never decremented below 0.
- err_o bits are set-dominant over err_clr_i in the same cycle.

Optional Feature:
- Macro: ORLINK_MCHAN_TIMEOUT_EN.
- When defined:
  - A 32-bit stall counter runs in H2F_DATA/F2H_DATA. It counts cycles where the FX2 side is ready (gotData_in or gotRoom_in high) but the channel is not.
  - It resets on any xfer.
  - On reaching TIMEOUT_CYCLES: set err_o[1] and treat the command as invalid-channel for the remainder (drain, or pad with 0x00).
- When undefined: no counter; err_o[1] is tied 0; the engine stalls indefinitely.

Test Plan:
- H2F chan 2, count 3, bytes A1 A2 A3, ready = 1 -> h2f_valid_o = 4'b0100 for 3 consecutive cycles with A1,A2,A3; back to IDLE; busy_o = 0.
- F2H chan 1, count 5, gotRoom = 1, valid = 1 -> 5 slwr pulses, 1 setup cycle first, pktEnd_out low for 1 cycle; count 512 -> no pktEnd.
- Header 0x85 (chan 5, NUM_CHAN = 4), count 2 -> 2 bytes 0x00 written, err_o = 2'b01, no f2h_ready_o; err_clr_i -> err_o = 0.
- Count 0, dir = 1 -> IDLE after DISPATCH; no slwr, no pktEnd, bus stays high-Z.
- H2F chan 0, ready toggled 1/0 every cycle, gotData low randomly -> byte order preserved, slrd never low without ready.
- Timeout macro on, TIMEOUT_CYCLES = 16, F2H valid held 0 -> after 16 stalled cycles err_o[1] = 1; remaining bytes = 0x00; command completes.
